// File: rtl/vpu_exec_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vpu_exec_issuer
//  Description : Accepts a vector op request, fetches up to SRC_CNT operands
//                from the register file (one read per cycle), issues them to
//                the exec unit, waits for completion with a timeout, and
//                holds the result on the writeback port until accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module vpu_exec_issuer #(
    parameter int DWIDTH  = 256,
    parameter int SRC_CNT = 3,
    parameter int ADDR_W  = 5,
    parameter int OPF_W   = 8,
    parameter int TMO     = 1023
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [OPF_W-1:0]            req_op_func_i,
    input  logic [SRC_CNT*ADDR_W-1:0]   req_src_addr_i,
    input  logic [1:0]                  req_src_cnt_i,
    input  logic [ADDR_W-1:0]           req_dst_addr_i,
    output logic                        rf_rd_en_o,
    output logic [ADDR_W-1:0]           rf_rd_addr_o,
    input  logic [DWIDTH-1:0]           rf_rd_data_i,
    output logic                        exec_start_o,
    output logic [OPF_W-1:0]            exec_op_func_o,
    output logic [SRC_CNT*DWIDTH-1:0]   exec_operand_o,
    output logic [SRC_CNT-1:0]          exec_operand_valid_o,
    input  logic [DWIDTH-1:0]           exec_dout_i,
    input  logic                        exec_done_i,
    output logic                        wb_valid_o,
    output logic [ADDR_W-1:0]           wb_addr_o,
    output logic [DWIDTH-1:0]           wb_data_o,
    input  logic                        wb_ready_i,
    output logic                        err_timeout_o
);

    localparam int c_tmr_w = $clog2(TMO + 1);
    localparam int c_n_w   = $clog2(SRC_CNT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        WB    = 3'd4
    } state_t;

    state_t                      r_state;
    logic                        r_ready;
    logic [OPF_W-1:0]            r_opf;
    logic [SRC_CNT*ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]           r_dst;
    logic [c_n_w-1:0]            r_n;
    logic [c_n_w-1:0]            r_fcnt;     // cycles spent in FETCH
    logic                        r_rd_en;
    logic [ADDR_W-1:0]           r_rd_addr;
    logic                        r_start;
    logic [SRC_CNT*DWIDTH-1:0]   r_operand;
    logic [SRC_CNT-1:0]          r_opvalid;
    logic [c_tmr_w-1:0]          r_tmr;
    logic                        r_wb_valid;
    logic [ADDR_W-1:0]           r_wb_addr;
    logic [DWIDTH-1:0]           r_wb_data;
    logic                        r_err;

    logic [c_n_w-1:0]            w_n_eff;
    logic [SRC_CNT-1:0]          w_mask;
    logic                        w_more;
    int                          w_next_idx;

    // Effective source count (0 means 1, clamp to SRC_CNT), slot mask and
    // whether another register-file read follows the current FETCH cycle.
    always_comb begin
        if (req_src_cnt_i == 2'd0) begin
            w_n_eff = c_n_w'(1);
        end else if (int'(req_src_cnt_i) > SRC_CNT) begin
            w_n_eff = c_n_w'(SRC_CNT);
        end else begin
            w_n_eff = c_n_w'(req_src_cnt_i);
        end
        w_mask = '0;
        for (int k = 0; k < SRC_CNT; k++) begin
            w_mask[k] = (k < int'(r_n));
        end
        w_more     = (int'(r_fcnt) + 1 < int'(r_n));
        w_next_idx = w_more ? int'(r_fcnt) + 1 : 0;
    end

    // Main control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_opf      <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_n        <= '0;
            r_fcnt     <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_start    <= 1'b0;
            r_operand  <= '0;
            r_opvalid  <= '0;
            r_tmr      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_opf     <= req_op_func_i;
                        r_src     <= req_src_addr_i;
                        r_dst     <= req_dst_addr_i;
                        r_n       <= w_n_eff;
                        r_operand <= '0;
                        r_fcnt    <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= req_src_addr_i[ADDR_W-1:0];
                        r_ready   <= 1'b0;
                        r_state   <= FETCH;
                    end
                end
                FETCH: begin
                    // Data for the read issued last cycle is on rf_rd_data_i now.
                    if (r_fcnt != '0) begin
                        r_operand[(int'(r_fcnt) - 1) * DWIDTH +: DWIDTH] <= rf_rd_data_i;
                    end
                    if (r_fcnt == r_n) begin
                        r_start   <= 1'b1;
                        r_opvalid <= w_mask;
                        r_state   <= ISSUE;
                    end else begin
                        r_fcnt <= r_fcnt + c_n_w'(1);
                    end
                    r_rd_en   <= w_more;
                    r_rd_addr <= w_more ? r_src[w_next_idx * ADDR_W +: ADDR_W] : '0;
                end
                ISSUE: begin
                    r_tmr   <= c_tmr_w'(1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (exec_done_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= r_dst;
                        r_wb_data  <= exec_dout_i;
                        r_opvalid  <= '0;
                        r_tmr      <= '0;
                        r_state    <= WB;
                    end else if (r_tmr == c_tmr_w'(TMO)) begin
                        r_err     <= 1'b1;
                        r_opvalid <= '0;
                        r_tmr     <= '0;
                        r_ready   <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                WB: begin
                    if (wb_ready_i) begin
                        r_wb_valid <= 1'b0;
                        r_ready    <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o          = r_ready;
    assign rf_rd_en_o           = r_rd_en;
    assign rf_rd_addr_o         = r_rd_addr;
    assign exec_start_o         = r_start;
    assign exec_op_func_o       = r_opf;
    assign exec_operand_o       = r_operand;
    assign exec_operand_valid_o = r_opvalid;
    assign wb_valid_o           = r_wb_valid;
    assign wb_addr_o            = r_wb_addr;
    assign wb_data_o            = r_wb_data;
    assign err_timeout_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vpu_exec_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vpu_exec_issuer
//  Description : Directed self-checking bench for vpu_exec_issuer with
//                scoreboards for register-file reads, issues and writebacks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vpu_exec_issuer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [7:0]    req_op_func_i;
    logic [14:0]   req_src_addr_i;
    logic [1:0]    req_src_cnt_i;
    logic [4:0]    req_dst_addr_i;
    logic          rf_rd_en_o;
    logic [4:0]    rf_rd_addr_o;
    logic [255:0]  rf_rd_data_i;
    logic          exec_start_o;
    logic [7:0]    exec_op_func_o;
    logic [767:0]  exec_operand_o;
    logic [2:0]    exec_operand_valid_o;
    logic [255:0]  exec_dout_i;
    logic          exec_done_i;
    logic          wb_valid_o;
    logic [4:0]    wb_addr_o;
    logic [255:0]  wb_data_o;
    logic          wb_ready_i;
    logic          err_timeout_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]   opf;
        logic [2:0]   vld;
        logic [767:0] ops;
    } iss_t;

    typedef struct {
        logic [4:0]   addr;
        logic [255:0] data;
    } wb_t;

    logic [4:0] q_rd[$];
    iss_t       q_iss[$];
    wb_t        q_wb[$];

    vpu_exec_issuer dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_op_func_i        (req_op_func_i),
        .req_src_addr_i       (req_src_addr_i),
        .req_src_cnt_i        (req_src_cnt_i),
        .req_dst_addr_i       (req_dst_addr_i),
        .rf_rd_en_o           (rf_rd_en_o),
        .rf_rd_addr_o         (rf_rd_addr_o),
        .rf_rd_data_i         (rf_rd_data_i),
        .exec_start_o         (exec_start_o),
        .exec_op_func_o       (exec_op_func_o),
        .exec_operand_o       (exec_operand_o),
        .exec_operand_valid_o (exec_operand_valid_o),
        .exec_dout_i          (exec_dout_i),
        .exec_done_i          (exec_done_i),
        .wb_valid_o           (wb_valid_o),
        .wb_addr_o            (wb_addr_o),
        .wb_data_o            (wb_data_o),
        .wb_ready_i           (wb_ready_i),
        .err_timeout_o        (err_timeout_o)
    );

    always #5 clk = ~clk;

    // Register-file contents: distinct word per address.
    function automatic logic [255:0] rf_word(input logic [4:0] a);
        return {8{3'b101, a, 24'h5A5A5A}};
    endfunction

    // Register file: one-cycle read latency.
    always @(posedge clk) begin
        rf_rd_data_i <= rf_rd_en_o ? rf_word(rf_rd_addr_o) : '0;
    end

    task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_wb(input logic [4:0] a, input logic [255:0] d);
        wb_t e;
        e.addr = a;
        e.data = d;
        q_wb.push_back(e);
    endtask

    // Drive one request for a single cycle and record what it must produce.
    task automatic issue_req(input logic [7:0] opf, input logic [4:0] s0, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [1:0] cnt, input logic [4:0] dst);
        logic [4:0] s[3];
        int   n;
        iss_t e;
        s[0] = s0; s[1] = s1; s[2] = s2;
        n = (cnt == 2'd0) ? 1 : int'(cnt);
        if (n > 3) n = 3;
        e.opf = opf;
        e.vld = '0;
        e.ops = '0;
        for (int k = 0; k < n; k++) begin
            q_rd.push_back(s[k]);
            e.vld[k] = 1'b1;
            e.ops[k*256 +: 256] = rf_word(s[k]);
        end
        q_iss.push_back(e);
        chk("req_ready_before_req", req_ready_o, 1);
        req_valid_i    = 1'b1;
        req_op_func_i  = opf;
        req_src_addr_i = {s2, s1, s0};
        req_src_cnt_i  = cnt;
        req_dst_addr_i = dst;
        tick;
        req_valid_i    = 1'b0;
    endtask

    task automatic wait_start(input int max);
        int n = 0;
        while (exec_start_o !== 1'b1 && n < max) begin
            tick;
            n++;
        end
        chk("start_seen", exec_start_o, 1);
    endtask

    // Read-address scoreboard.
    always @(negedge clk) begin
        if (rf_rd_en_o === 1'b1) begin
            checks++;
            assert (q_rd.size() > 0) else begin
                errors++;
                $error("FAIL rd_unexpected observed=%0h expected=none", rf_rd_addr_o);
            end
            if (q_rd.size() > 0) chk("rd_addr", rf_rd_addr_o, q_rd.pop_front());
        end
    end

    // Issue scoreboard.
    always @(negedge clk) begin
        if (exec_start_o === 1'b1) begin
            iss_t e;
            checks++;
            assert (q_iss.size() > 0) else begin
                errors++;
                $error("FAIL issue_unexpected observed=1 expected=0");
            end
            if (q_iss.size() > 0) begin
                e = q_iss.pop_front();
                chk("iss_opf", exec_op_func_o, e.opf);
                chk("iss_valid", exec_operand_valid_o, e.vld);
                chk("iss_ops", exec_operand_o, e.ops);
            end
        end
    end

    // Writeback scoreboard: compare on the handshake cycle.
    always @(negedge clk) begin
        if (wb_valid_o === 1'b1 && wb_ready_i === 1'b1) begin
            wb_t e;
            checks++;
            assert (q_wb.size() > 0) else begin
                errors++;
                $error("FAIL wb_unexpected observed=%0h expected=none", wb_data_o);
            end
            if (q_wb.size() > 0) begin
                e = q_wb.pop_front();
                chk("wb_addr", wb_addr_o, e.addr);
                chk("wb_data", wb_data_o, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] r1, r2, r3, r5;
        r1 = {4{64'h1111_2222_3333_4444}};
        r2 = {4{64'hDEAD_BEEF_0000_0002}};
        r3 = {4{64'h0123_4567_89AB_CDEF}};
        r5 = {4{64'h5555_AAAA_5555_AAAA}};

        rst_n = 1'b0; req_valid_i = 1'b0; req_op_func_i = '0; req_src_addr_i = '0;
        req_src_cnt_i = '0; req_dst_addr_i = '0; exec_dout_i = '0; exec_done_i = 1'b0;
        wb_ready_i = 1'b1;
        tick; tick; tick;
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rd_en", rf_rd_en_o, 0);
        chk("rst_start", exec_start_o, 0);
        chk("rst_opvalid", exec_operand_valid_o, 0);
        chk("rst_operand", exec_operand_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_err", err_timeout_o, 0);
        rst_n = 1'b1;
        tick;

        // Spurious done while idle.
        exec_done_i = 1'b1; exec_dout_i = r1;
        tick;
        exec_done_i = 1'b0;
        tick;
        chk("idle_done_ready", req_ready_o, 1);
        chk("idle_done_wb", wb_valid_o, 0);

        // n=2, src {3,7}; spurious done in FETCH and ISSUE; done at start+3.
        issue_req(8'h5A, 5'd3, 5'd7, 5'd0, 2'd2, 5'd9);
        chk("s1_rd_en_t1", rf_rd_en_o, 1);
        chk("s1_rd_addr_t1", rf_rd_addr_o, 3);
        chk("s1_ready_t1", req_ready_o, 0);
        exec_done_i = 1'b1;
        tick;
        exec_done_i = 1'b0;
        chk("s1_rd_addr_t2", rf_rd_addr_o, 7);
        tick;
        chk("s1_rd_en_t3", rf_rd_en_o, 0);
        chk("s1_start_t3", exec_start_o, 0);
        tick;
        chk("s1_start_t4", exec_start_o, 1);
        chk("s1_opvalid", exec_operand_valid_o, 3'b011);
        exec_done_i = 1'b1; exec_dout_i = r2;
        tick;
        exec_done_i = 1'b0;
        chk("s1_start_off", exec_start_o, 0);
        chk("s1_issue_done_ignored", wb_valid_o, 0);
        tick;
        chk("s1_hold_ops", exec_operand_o, {256'h0, rf_word(5'd7), rf_word(5'd3)});
        chk("s1_hold_opf", exec_op_func_o, 8'h5A);
        tick;
        exec_done_i = 1'b1; exec_dout_i = r1;
        push_wb(5'd9, r1);
        tick;
        exec_done_i = 1'b0;
        chk("s1_wb_valid", wb_valid_o, 1);
        chk("s1_opvalid_clear", exec_operand_valid_o, 0);
        tick;
        chk("s1_wb_drop", wb_valid_o, 0);
        chk("s1_idle", req_ready_o, 1);

        // n=0 treated as 1; request back-to-back in first IDLE cycle.
        issue_req(8'hC3, 5'd12, 5'd0, 5'd0, 2'd0, 5'd4);
        chk("s2_rd_en_t1", rf_rd_en_o, 1);
        tick;
        chk("s2_rd_en_t2", rf_rd_en_o, 0);
        tick;
        chk("s2_start_t3", exec_start_o, 1);
        chk("s2_opvalid", exec_operand_valid_o, 3'b001);
        tick;
        exec_done_i = 1'b1; exec_dout_i = r2;
        push_wb(5'd4, r2);
        tick;
        exec_done_i = 1'b0;
        chk("s2_wb_valid", wb_valid_o, 1);
        tick;
        chk("s2_idle", req_ready_o, 1);

        // n=3; writeback stalled for 5 cycles.
        issue_req(8'h11, 5'd1, 5'd30, 5'd17, 2'd3, 5'd21);
        tick; tick; tick;
        chk("s3_start_t4", exec_start_o, 0);
        tick;
        chk("s3_start_t5", exec_start_o, 1);
        chk("s3_opvalid", exec_operand_valid_o, 3'b111);
        tick;
        tick;
        exec_done_i = 1'b1; exec_dout_i = r3; wb_ready_i = 1'b0;
        push_wb(5'd21, r3);
        tick;
        exec_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("s3_hold_valid", wb_valid_o, 1);
            chk("s3_hold_addr", wb_addr_o, 21);
            chk("s3_hold_data", wb_data_o, r3);
            chk("s3_hold_ready", req_ready_o, 0);
            tick;
        end
        wb_ready_i = 1'b1;
        chk("s3_valid_at_hs", wb_valid_o, 1);
        tick;
        chk("s3_after_hs_valid", wb_valid_o, 0);
        chk("s3_after_hs_ready", req_ready_o, 1);

        // Timeout: no done at all.
        issue_req(8'h77, 5'd20, 5'd0, 5'd0, 2'd1, 5'd2);
        wait_start(8);
        for (int i = 0; i < 1023; i++) tick;
        chk("tmo_err_early", err_timeout_o, 0);
        chk("tmo_ready_early", req_ready_o, 0);
        tick;
        chk("tmo_err_pulse", err_timeout_o, 1);
        chk("tmo_ready", req_ready_o, 1);
        chk("tmo_no_wb", wb_valid_o, 0);

        // Back-to-back after timeout; done at exactly start+1023.
        issue_req(8'h78, 5'd22, 5'd0, 5'd0, 2'd1, 5'd3);
        chk("tmo_err_one_cycle", err_timeout_o, 0);
        wait_start(8);
        for (int i = 0; i < 1023; i++) tick;
        exec_done_i = 1'b1; exec_dout_i = r5;
        push_wb(5'd3, r5);
        tick;
        exec_done_i = 1'b0;
        chk("tmo_edge_wb", wb_valid_o, 1);
        chk("tmo_edge_err", err_timeout_o, 0);
        tick;
        chk("tmo_edge_idle", req_ready_o, 1);

        // Reset during WAIT, then a late done.
        issue_req(8'h99, 5'd5, 5'd0, 5'd0, 2'd1, 5'd6);
        wait_start(8);
        tick; tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("wrst_ready", req_ready_o, 1);
        chk("wrst_opvalid", exec_operand_valid_o, 0);
        chk("wrst_operand", exec_operand_o, 0);
        chk("wrst_opf", exec_op_func_o, 0);
        chk("wrst_wb", wb_valid_o, 0);
        exec_done_i = 1'b1; exec_dout_i = r1;
        tick;
        exec_done_i = 1'b0;
        tick; tick;
        chk("wrst_late_wb", wb_valid_o, 0);
        chk("wrst_late_err", err_timeout_o, 0);
        chk("wrst_late_ready", req_ready_o, 1);

        chk("rd_q_empty", q_rd.size(), 0);
        chk("iss_q_empty", q_iss.size(), 0);
        chk("wb_q_empty", q_wb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
